cache_rd_arbiter: RTL and testbench

Shares one AXI read-address/read-data channel pair between the ICache and DCache miss/refill ports. Accepts cache-style read requests (rd_req/rd_rdy, ret_valid/ret_last), grants one requester at a time with round-robin priority, issues a single AXI AR transaction, and steers the R beats back to the granted cache. It sits between the two Cache instances and the AXI master side of the bridge, and has at most one outstanding read.

---
 rtl/cache_rd_arbiter_if.sv | 58 +++++
 rtl/cache_rd_arbiter.sv | 103 ++++++++++
 tb/tb_cache_rd_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_rd_arbiter_if.sv
// Bundle of both cache read ports and the AXI read channels.
// master is the arbiter's view, slave the caches/AXI view.
interface cache_rd_arbiter_if;
  logic        i_rd_req;
  logic [1:0]  i_rd_type;
  logic [31:0] i_rd_addr;
  logic        i_rd_rdy;
  logic        i_ret_valid;
  logic        i_ret_last;
  logic [31:0] i_ret_data;
  logic        d_rd_req;
  logic [1:0]  d_rd_type;
  logic [31:0] d_rd_addr;
  logic        d_rd_rdy;
  logic        d_ret_valid;
  logic        d_ret_last;
  logic [31:0] d_ret_data;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    input  i_rd_req, i_rd_type, i_rd_addr,
    output i_rd_rdy, i_ret_valid, i_ret_last, i_ret_data,
    input  d_rd_req, d_rd_type, d_rd_addr,
    output d_rd_rdy, d_ret_valid, d_ret_last, d_ret_data,
    output arid, araddr, arlen, arsize, arburst,
    output arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    output i_rd_req, i_rd_type, i_rd_addr,
    input  i_rd_rdy, i_ret_valid, i_ret_last, i_ret_data,
    output d_rd_req, d_rd_type, d_rd_addr,
    input  d_rd_rdy, d_ret_valid, d_ret_last, d_ret_data,
    input  arid, araddr, arlen, arsize, arburst,
    input  arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/cache_rd_arbiter.sv
// Round-robin ICache/DCache read arbiter onto one AXI AR/R pair.
// Single outstanding read; R beats steered back by rid.
module cache_rd_arbiter #(
  parameter logic [3:0] ID_I = 4'd0,
  parameter logic [3:0] ID_D = 4'd1
) (
  input logic              aclk,
  input logic              areset,
  cache_rd_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_R
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_last_d;
  logic        r_owner_d;
  logic [31:0] r_addr;
  logic [1:0]  r_type;
  logic        w_gnt_i;
  logic        w_gnt_d;
  logic [3:0]  w_owner_id;
  logic        w_hit;

  // Winner selection: a tie goes to whoever was not granted last
  always_comb begin
    w_gnt_d = (r_state == S_IDLE) && bus.d_rd_req &&
              (!bus.i_rd_req || !r_last_d);
    w_gnt_i = (r_state == S_IDLE) && bus.i_rd_req && !w_gnt_d;
  end

  assign w_owner_id = r_owner_d ? ID_D : ID_I;
  assign w_hit      = bus.rvalid && (bus.rid == w_owner_id);

  // State register and latched request of the granted cache
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state   <= S_IDLE;
      r_last_d  <= 1'b0;
      r_owner_d <= 1'b0;
      r_addr    <= 32'd0;
      r_type    <= 2'd0;
    end else begin
      r_state <= w_next;
      if (w_gnt_i || w_gnt_d) begin
        r_owner_d <= w_gnt_d;
        r_last_d  <= w_gnt_d;
        r_addr    <= w_gnt_d ? bus.d_rd_addr : bus.i_rd_addr;
        r_type    <= w_gnt_d ? bus.d_rd_type : bus.i_rd_type;
      end
    end
  end

  // Next state and all handshake/return outputs
  always_comb begin
    w_next          = r_state;
    bus.i_rd_rdy    = 1'b0;
    bus.d_rd_rdy    = 1'b0;
    bus.i_ret_valid = 1'b0;
    bus.i_ret_last  = 1'b0;
    bus.i_ret_data  = bus.rdata;
    bus.d_ret_valid = 1'b0;
    bus.d_ret_last  = 1'b0;
    bus.d_ret_data  = bus.rdata;
    bus.arvalid     = 1'b0;
    bus.rready      = 1'b0;
    bus.arid        = w_owner_id;
    bus.araddr      = r_addr;
    bus.arlen       = (r_type == 2'b11) ? 8'd3 : 8'd0;
    bus.arsize      = (r_type == 2'b11) ? 3'd2 : {1'b0, r_type};
    bus.arburst     = 2'b01;
    bus.arlock      = 2'b00;
    bus.arcache     = 4'd0;
    bus.arprot      = 3'd0;
    unique case (r_state)
      S_IDLE: begin
        bus.i_rd_rdy = w_gnt_i;
        bus.d_rd_rdy = w_gnt_d;
        if (w_gnt_i || w_gnt_d) w_next = S_AR;
      end
      S_AR: begin
        bus.arvalid = 1'b1;
        if (bus.arready) w_next = S_R;
      end
      S_R: begin
        bus.rready = 1'b1;
        if (w_hit) begin
          bus.i_ret_valid = !r_owner_d;
          bus.i_ret_last  = !r_owner_d && bus.rlast;
          bus.d_ret_valid = r_owner_d;
          bus.d_ret_last  = r_owner_d && bus.rlast;
          if (bus.rlast) w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Directed bench for cache_rd_arbiter: transaction-level model
// compared every cycle, plus literal checks on directed vectors.
module tb_cache_rd_arbiter;
  logic aclk = 1'b0;
  logic areset = 1'b1;
  int   n_pass = 0;
  int   n_tot = 0;

  cache_rd_arbiter_if bus ();

  cache_rd_arbiter dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  always #5 aclk = ~aclk;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    n_tot++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Transaction-level model: one read in flight, in address or data phase
  bit          m_known = 0;
  bit          m_busy = 0;
  bit          m_in_ar = 0;
  bit          m_own_d = 0;
  bit          m_pref_d = 1;
  logic [31:0] m_addr = 0;
  logic [1:0]  m_type = 0;

  always @(negedge aclk) begin
    bit win_i, win_d, hit;
    win_d = bus.d_rd_req && (!bus.i_rd_req || m_pref_d);
    win_i = bus.i_rd_req && !win_d;
    hit   = bus.rvalid && (bus.rid == (m_own_d ? 4'd1 : 4'd0));
    if (m_known) begin
      chk("m_i_rdy", bus.i_rd_rdy, !m_busy && win_i);
      chk("m_d_rdy", bus.d_rd_rdy, !m_busy && win_d);
      chk("m_arvalid", bus.arvalid, m_busy && m_in_ar);
      chk("m_rready", bus.rready, m_busy && !m_in_ar);
      if (m_busy && m_in_ar) begin
        chk("m_araddr", bus.araddr, m_addr);
        chk("m_arid", bus.arid, m_own_d ? 1 : 0);
        chk("m_arlen", bus.arlen, m_type == 3 ? 3 : 0);
        chk("m_arsize", bus.arsize, m_type == 3 ? 2 : m_type);
        chk("m_arburst", bus.arburst, 1);
      end
      chk("m_i_ret_v", bus.i_ret_valid,
          m_busy && !m_in_ar && hit && !m_own_d);
      chk("m_d_ret_v", bus.d_ret_valid,
          m_busy && !m_in_ar && hit && m_own_d);
      chk("m_i_ret_l", bus.i_ret_last,
          m_busy && !m_in_ar && hit && !m_own_d && bus.rlast);
      chk("m_d_ret_l", bus.d_ret_last,
          m_busy && !m_in_ar && hit && m_own_d && bus.rlast);
      if (bus.i_ret_valid) chk("m_i_data", bus.i_ret_data, bus.rdata);
      if (bus.d_ret_valid) chk("m_d_data", bus.d_ret_data, bus.rdata);
    end
    if (areset) begin
      m_known  = 1;
      m_busy   = 0;
      m_pref_d = 1;
    end else if (!m_busy) begin
      if (win_i || win_d) begin
        m_busy   = 1;
        m_in_ar  = 1;
        m_own_d  = win_d;
        m_pref_d = win_i;
        m_addr   = win_d ? bus.d_rd_addr : bus.i_rd_addr;
        m_type   = win_d ? bus.d_rd_type : bus.i_rd_type;
      end
    end else if (m_in_ar) begin
      if (bus.arready) m_in_ar = 0;
    end else if (hit && bus.rlast) begin
      m_busy = 0;
    end
  end

  task automatic beat(logic [3:0] id, logic [31:0] d, logic l);
    bus.rvalid = 1'b1;
    bus.rid    = id;
    bus.rdata  = d;
    bus.rlast  = l;
  endtask

  task automatic no_beat();
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
  endtask

  initial begin
    bus.i_rd_req = 0; bus.i_rd_type = 0; bus.i_rd_addr = 0;
    bus.d_rd_req = 0; bus.d_rd_type = 0; bus.d_rd_addr = 0;
    bus.arready = 0; bus.rid = 0; bus.rdata = 0;
    bus.rresp = 0; bus.rlast = 0; bus.rvalid = 0;
    step();
    step();
    areset = 1'b0;
    #1;
    chk("rst_arvalid", bus.arvalid, 0);
    chk("rst_rready", bus.rready, 0);
    chk("rst_i_ret", bus.i_ret_valid, 0);

    // ICache line read, immediate arready, four beats
    bus.i_rd_req = 1; bus.i_rd_type = 2'b11;
    bus.i_rd_addr = 32'h1FC0_0000;
    #1;
    chk("t1_i_rdy", bus.i_rd_rdy, 1);
    chk("t1_d_rdy", bus.d_rd_rdy, 0);
    step();
    bus.i_rd_req = 0; bus.i_rd_addr = 32'hFFFF_FFFF;
    bus.arready = 1;
    #1;
    chk("t1_arvalid", bus.arvalid, 1);
    chk("t1_araddr", bus.araddr, 32'h1FC0_0000);
    chk("t1_arlen", bus.arlen, 3);
    chk("t1_arsize", bus.arsize, 2);
    chk("t1_arid", bus.arid, 0);
    step();
    bus.arready = 0;
    for (int k = 0; k < 4; k++) begin
      beat(4'd0, 32'hA0 + k, k == 3);
      #1;
      chk("t1_i_ret_v", bus.i_ret_valid, 1);
      chk("t1_i_data", bus.i_ret_data, 32'hA0 + k);
      chk("t1_i_last", bus.i_ret_last, k == 3);
      chk("t1_d_ret_v", bus.d_ret_valid, 0);
      step();
    end
    no_beat();
    #1;
    chk("t1_idle_rready", bus.rready, 0);

    // Tie after reset: DCache first, then ICache, then DCache again
    bus.i_rd_req = 1; bus.i_rd_type = 2'b10; bus.i_rd_addr = 32'h100;
    bus.d_rd_req = 1; bus.d_rd_type = 2'b10; bus.d_rd_addr = 32'h200;
    #1;
    chk("t2_d_rdy", bus.d_rd_rdy, 1);
    chk("t2_i_rdy", bus.i_rd_rdy, 0);
    step();
    bus.d_rd_req = 0; bus.arready = 1;
    #1;
    chk("t2_arid_d", bus.arid, 1);
    chk("t2_i_rdy_ar", bus.i_rd_rdy, 0);
    step();
    bus.arready = 1;
    beat(4'd1, 32'h11, 1);
    #1;
    chk("t2_d_ret", bus.d_ret_valid, 1);
    chk("t2_i_rdy_r", bus.i_rd_rdy, 0);
    step();
    bus.arready = 0;
    no_beat();
    #1;
    chk("t2_i_rdy_next", bus.i_rd_rdy, 1);
    step();
    bus.i_rd_req = 0; bus.arready = 1;
    #1;
    chk("t2_arid_i", bus.arid, 0);
    chk("t2_araddr_i", bus.araddr, 32'h100);
    step();
    bus.arready = 0;
    beat(4'd0, 32'h22, 1);
    step();
    no_beat();
    bus.i_rd_req = 1; bus.d_rd_req = 1;
    #1;
    chk("t2_tie2_d", bus.d_rd_rdy, 1);
    chk("t2_tie2_i", bus.i_rd_rdy, 0);
    step();
    bus.i_rd_req = 0; bus.d_rd_req = 0; bus.arready = 1;
    step();
    bus.arready = 0;
    beat(4'd1, 32'h33, 1);
    step();
    no_beat();

    // DCache word read with arready held low five cycles
    bus.d_rd_req = 1; bus.d_rd_type = 2'b10;
    bus.d_rd_addr = 32'h8000_0004;
    step();
    bus.d_rd_req = 0; bus.d_rd_addr = 32'h0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t3_arvalid", bus.arvalid, 1);
      chk("t3_araddr", bus.araddr, 32'h8000_0004);
      step();
    end
    bus.arready = 1;
    #1;
    chk("t3_arlen", bus.arlen, 0);
    chk("t3_arsize", bus.arsize, 2);
    step();
    bus.arready = 0;
    beat(4'd1, 32'hDEAD_BEEF, 1);
    #1;
    chk("t3_d_ret_v", bus.d_ret_valid, 1);
    chk("t3_d_ret_l", bus.d_ret_last, 1);
    chk("t3_d_data", bus.d_ret_data, 32'hDEAD_BEEF);
    step();
    no_beat();

    // Byte read with a stray rid=0 beat in the DCache data phase
    bus.d_rd_req = 1; bus.d_rd_type = 2'b00;
    bus.d_rd_addr = 32'h8000_0013;
    step();
    bus.d_rd_req = 0; bus.arready = 1;
    #1;
    chk("t4_arsize", bus.arsize, 0);
    chk("t4_arlen", bus.arlen, 0);
    step();
    bus.arready = 0;
    beat(4'd0, 32'h55, 1);
    #1;
    chk("t4_stray_i", bus.i_ret_valid, 0);
    chk("t4_stray_d", bus.d_ret_valid, 0);
    step();
    no_beat();
    #1;
    chk("t4_still_r", bus.rready, 1);
    step();
    beat(4'd1, 32'h77, 1);
    #1;
    chk("t4_d_data", bus.d_ret_data, 32'h77);
    step();
    no_beat();

    // Reset during the second beat of an ICache line read
    bus.i_rd_req = 1; bus.i_rd_type = 2'b11; bus.i_rd_addr = 32'h300;
    step();
    bus.i_rd_req = 0; bus.arready = 1;
    step();
    bus.arready = 0;
    beat(4'd0, 32'hB0, 0);
    step();
    beat(4'd0, 32'hB1, 0);
    areset = 1;
    step();
    areset = 0;
    no_beat();
    bus.i_rd_req = 1; bus.i_rd_type = 2'b10; bus.i_rd_addr = 32'h400;
    #1;
    chk("t5_arvalid", bus.arvalid, 0);
    chk("t5_rready", bus.rready, 0);
    chk("t5_i_ret", bus.i_ret_valid, 0);
    chk("t5_i_rdy", bus.i_rd_rdy, 1);
    step();
    bus.i_rd_req = 0; bus.arready = 1;
    #1;
    chk("t5_araddr", bus.araddr, 32'h400);
    step();
    bus.arready = 0;
    beat(4'd0, 32'hC0, 1);
    step();
    no_beat();
    step();
    @(posedge aclk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
